// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON request arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   OP_ENC / OP_DEC : per-request operation code
//   TIMEOUT_CYC_DEF : default BUSY-cycle budget before a job is aborted
package ascon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BUSY,
      ST_SETTLE,
      ST_RESP
   } arb_state_t;

   localparam logic OP_ENC = 1'b0;
   localparam logic OP_DEC = 1'b1;

   localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/ascon_req_arbiter_if.sv
// Bundle of request, response and engine-side signals of the arbiter.
//   slave  : the arbiter view (consumes requests/engine results, drives grants,
//            responses and engine controls)
//   master : the view of the requesters and the engine
interface ascon_req_arbiter_if;

   logic [1:0]   req;
   logic [1:0]   req_op;
   logic [127:0] req_nonce0;
   logic [127:0] req_nonce1;
   logic [31:0]  req_pt0;
   logic [31:0]  req_pt1;
   logic [159:0] req_ct0;
   logic [159:0] req_ct1;
   logic [1:0]   gnt;

   logic [1:0]   rsp_valid;
   logic [1:0]   rsp_ready;
   logic [31:0]  rsp_data;
   logic [127:0] rsp_tag;
   logic         rsp_fail;
   logic         rsp_timeout;

   logic         eng_en;
   logic         eng_enc_start;
   logic         eng_dec_start;
   logic [127:0] eng_nonce;
   logic [31:0]  eng_pt;
   logic [159:0] eng_ct;
   logic         eng_enc_done;
   logic         eng_auth_done;
   logic         eng_dec_fail;
   logic [31:0]  eng_msg;
   logic [127:0] eng_tag;

   modport slave (
      input  req, req_op, req_nonce0, req_nonce1, req_pt0, req_pt1, req_ct0, req_ct1,
      output gnt,
      output rsp_valid, rsp_data, rsp_tag, rsp_fail, rsp_timeout,
      input  rsp_ready,
      output eng_en, eng_enc_start, eng_dec_start, eng_nonce, eng_pt, eng_ct,
      input  eng_enc_done, eng_auth_done, eng_dec_fail, eng_msg, eng_tag
   );

   modport master (
      output req, req_op, req_nonce0, req_nonce1, req_pt0, req_pt1, req_ct0, req_ct1,
      input  gnt,
      input  rsp_valid, rsp_data, rsp_tag, rsp_fail, rsp_timeout,
      output rsp_ready,
      input  eng_en, eng_enc_start, eng_dec_start, eng_nonce, eng_pt, eng_ct,
      output eng_enc_done, eng_auth_done, eng_dec_fail, eng_msg, eng_tag
   );

endinterface

// File: rtl/ascon_rr_arb2.sv
// Two-port round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   take     : the current pick is being accepted; update the pointer
//   pick     : one-hot winner (0 when no request)
//   win_id   : index of the winner
// The pointer holds the last-granted port and resets to 1 so port 0 wins
// the first contention.
module ascon_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] pick,
   output logic       win_id
);

   logic last;

   always_comb begin
      win_id = 1'b0;
      pick   = 2'b00;
      case (req)
         2'b01:   win_id = 1'b0;
         2'b10:   win_id = 1'b1;
         2'b11:   win_id = ~last;
         default: win_id = 1'b0;
      endcase
      if (req != 2'b00)
         pick = win_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (take)
         last <= win_id;
   end

endmodule

// File: rtl/ascon_req_arbiter.sv
// Arbitrates two requesters onto one ASCON engine and returns the result to
// the granted port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response/engine bundle (slave view)
//   TIMEOUT_CYC : BUSY cycles allowed before the job is aborted
//
// state  | meaning
// IDLE   | sample req, grant a winner and latch its job
// START  | one-cycle start pulse to the engine
// BUSY   | wait for engine completion or timeout
// SETTLE | one cycle after decrypt auth done before capturing fail/msg
// RESP   | hold response until the owning port accepts it
module ascon_req_arbiter
   import ascon_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic clk,
   input logic rst,
   ascon_req_arbiter_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   arb_state_t   state, nxt;
   logic [1:0]   pick;
   logic         win_id;
   logic         do_grant, do_enc_cap, do_dec_cap, do_tmo, do_hs;

   logic         job_op;
   logic         job_id;
   logic [127:0] job_nonce;
   logic [31:0]  job_pt;
   logic [159:0] job_ct;
   logic [TW-1:0] tmo_cnt;
   logic         tmo_hit;

   logic [1:0]   gnt_q;
   logic [31:0]  rsp_data_q;
   logic [127:0] rsp_tag_q;
   logic         rsp_fail_q;
   logic         rsp_timeout_q;

   ascon_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bus.req),
      .take   (do_grant),
      .pick   (pick),
      .win_id (win_id)
   );

   // Last permitted BUSY cycle: the counter starts at 0 on the first one.
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt        = state;
      do_grant   = 1'b0;
      do_enc_cap = 1'b0;
      do_dec_cap = 1'b0;
      do_tmo     = 1'b0;
      do_hs      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               do_grant = 1'b1;
               nxt      = ST_START;
            end
         end
         ST_START: nxt = ST_BUSY;
         ST_BUSY: begin
            // Completion wins over a timeout landing on the same cycle.
            if (job_op == OP_ENC && bus.eng_enc_done) begin
               do_enc_cap = 1'b1;
               nxt        = ST_RESP;
            end else if (job_op == OP_DEC && bus.eng_auth_done) begin
               nxt = ST_SETTLE;
            end else if (tmo_hit) begin
               do_tmo = 1'b1;
               nxt    = ST_RESP;
            end
         end
         ST_SETTLE: begin
            do_dec_cap = 1'b1;
            nxt        = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready[job_id]) begin
               do_hs = 1'b1;
               nxt   = ST_IDLE;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q         <= '0;
         job_op        <= 1'b0;
         job_id        <= 1'b0;
         job_nonce     <= '0;
         job_pt        <= '0;
         job_ct        <= '0;
         tmo_cnt       <= '0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_fail_q    <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         gnt_q <= '0;
         if (do_grant) begin
            gnt_q     <= pick;
            job_id    <= win_id;
            job_op    <= bus.req_op[win_id];
            job_nonce <= win_id ? bus.req_nonce1 : bus.req_nonce0;
            job_pt    <= win_id ? bus.req_pt1    : bus.req_pt0;
            job_ct    <= win_id ? bus.req_ct1    : bus.req_ct0;
         end
         if (state == ST_START)
            tmo_cnt <= '0;
         else if (state == ST_BUSY)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (do_enc_cap) begin
            rsp_tag_q  <= bus.eng_tag;
            rsp_data_q <= bus.eng_msg;
            rsp_fail_q <= 1'b0;
         end
         if (do_dec_cap) begin
            rsp_fail_q <= bus.eng_dec_fail;
            rsp_data_q <= bus.eng_msg;
            rsp_tag_q  <= '0;
         end
         if (do_tmo) begin
            rsp_timeout_q <= 1'b1;
            rsp_fail_q    <= 1'b1;
            rsp_data_q    <= '0;
         end
         if (do_hs)
            rsp_timeout_q <= 1'b0;
      end
   end

   assign bus.gnt           = gnt_q;
   assign bus.rsp_valid     = (state == ST_RESP) ? (job_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.rsp_tag       = rsp_tag_q;
   assign bus.rsp_fail      = rsp_fail_q;
   assign bus.rsp_timeout   = rsp_timeout_q;

   // Dropping eng_en in IDLE/RESP lets the engine clear its done flags.
   assign bus.eng_en        = (state == ST_START) || (state == ST_BUSY) || (state == ST_SETTLE);
   assign bus.eng_enc_start = (state == ST_START) && (job_op == OP_ENC);
   assign bus.eng_dec_start = (state == ST_START) && (job_op == OP_DEC);
   assign bus.eng_nonce     = job_nonce;
   assign bus.eng_pt        = job_pt;
   assign bus.eng_ct        = job_ct;

endmodule
